// File: rtl/sm4_perf_monitor_if.sv
// rtl/sm4_perf_monitor_if.sv - encryptor/key-cache event strobes observed by the performance monitor
interface sm4_perf_monitor_if #(
    parameter int NUM_WAYS = 4
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic             start_i;
    logic             check_i;
    logic             miss_i;
    logic [WAY_W-1:0] replace_way_i;
    logic             done_i;

    modport master (
        output start_i,
        output check_i,
        output miss_i,
        output replace_way_i,
        output done_i
    );

    modport slave (
        input start_i,
        input check_i,
        input miss_i,
        input replace_way_i,
        input done_i
    );
endinterface

// File: rtl/sm4_perf_monitor.sv
// rtl/sm4_perf_monitor.sv - per-transaction latency, key-cache miss and eviction statistics
module sm4_perf_monitor #(
    parameter int NUM_WAYS = 4,
    parameter int CYCLE_W  = 8,
    parameter int CNT_W    = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    sm4_perf_monitor_if.slave           evt,
    input  logic                        clear_i,
    input  logic [$clog2(NUM_WAYS)-1:0] way_sel_i,
    output logic                        busy_o,
    output logic [CYCLE_W-1:0]          cycle_o,
    output logic [CYCLE_W-1:0]          last_latency_o,
    output logic                        last_miss_o,
    output logic [$clog2(NUM_WAYS)-1:0] last_way_o,
    output logic [CNT_W-1:0]            txn_count_o,
    output logic [CNT_W-1:0]            miss_count_o,
    output logic [CYCLE_W-1:0]          max_latency_o,
    output logic [CYCLE_W-1:0]          min_latency_o,
    output logic [CNT_W-1:0]            way_evict_o,
    output logic                        overflow_o
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    localparam logic [CYCLE_W-1:0] CYC_MAX = '1;
    localparam logic [CYCLE_W-1:0] CYC_ONE = 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [CYCLE_W-1:0] cycle_q,     cycle_d;
    logic               checked_q,   checked_d;
    logic               pend_miss_q, pend_miss_d;
    logic [WAY_W-1:0]   pend_way_q,  pend_way_d;
    logic [CYCLE_W-1:0] last_lat_q,  last_lat_d;
    logic               last_miss_q, last_miss_d;
    logic [WAY_W-1:0]   last_way_q,  last_way_d;
    logic [CNT_W-1:0]   txn_q,       txn_d;
    logic [CNT_W-1:0]   miss_cnt_q,  miss_cnt_d;
    logic [CYCLE_W-1:0] max_q,       max_d;
    logic [CYCLE_W-1:0] min_q,       min_d;
    logic               ovf_q,       ovf_d;
    logic [CNT_W-1:0]   evict_q [NUM_WAYS];
    logic [CNT_W-1:0]   evict_d [NUM_WAYS];

    logic               eff_miss;
    logic [WAY_W-1:0]   eff_way;
    logic [CYCLE_W-1:0] lat;

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        checked_d   = checked_q;
        pend_miss_d = pend_miss_q;
        pend_way_d  = pend_way_q;
        last_lat_d  = last_lat_q;
        last_miss_d = last_miss_q;
        last_way_d  = last_way_q;
        txn_d       = txn_q;
        miss_cnt_d  = miss_cnt_q;
        max_d       = max_q;
        min_d       = min_q;
        ovf_d       = ovf_q;
        evict_d     = evict_q;
        eff_miss    = pend_miss_q;
        eff_way     = pend_way_q;
        lat         = cycle_q;

        case (state_q)
            IDLE: begin
                if (evt.start_i) begin
                    state_d     = RUN;
                    cycle_d     = '0;
                    checked_d   = 1'b0;
                    pend_miss_d = 1'b0;
                    pend_way_d  = '0;
                end
            end
            RUN: begin
                // lat is both the next cycle count and the latency reported on a done edge
                if (cycle_q == CYC_MAX) begin
                    lat   = CYC_MAX;
                    ovf_d = 1'b1;
                end else begin
                    lat = cycle_q + CYC_ONE;
                end
                cycle_d = lat;

                if (evt.check_i && !checked_q) begin
                    checked_d   = 1'b1;
                    pend_miss_d = evt.miss_i;
                    pend_way_d  = evt.miss_i ? evt.replace_way_i : '0;
                    eff_miss    = pend_miss_d;
                    eff_way     = pend_way_d;
                end

                if (evt.done_i) begin
                    state_d     = IDLE;
                    last_lat_d  = lat;
                    last_miss_d = eff_miss;
                    last_way_d  = eff_way;

                    if (txn_q == CNT_MAX) ovf_d = 1'b1;
                    else                  txn_d = txn_q + CNT_ONE;

                    if (eff_miss) begin
                        if (miss_cnt_q == CNT_MAX) ovf_d      = 1'b1;
                        else                       miss_cnt_d = miss_cnt_q + CNT_ONE;
                        if (evict_q[eff_way] == CNT_MAX) ovf_d = 1'b1;
                        else evict_d[eff_way] = evict_q[eff_way] + CNT_ONE;
                    end

                    if (lat > max_q) max_d = lat;
                    if (lat < min_q) min_d = lat;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides any statistic update of the same cycle; last_* and the FSM are untouched
        if (clear_i) begin
            txn_d      = '0;
            miss_cnt_d = '0;
            max_d      = '0;
            min_d      = CYC_MAX;
            ovf_d      = 1'b0;
            for (int i = 0; i < NUM_WAYS; i++) evict_d[i] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            cycle_q     <= '0;
            checked_q   <= 1'b0;
            pend_miss_q <= 1'b0;
            pend_way_q  <= '0;
            last_lat_q  <= '0;
            last_miss_q <= 1'b0;
            last_way_q  <= '0;
            txn_q       <= '0;
            miss_cnt_q  <= '0;
            max_q       <= '0;
            min_q       <= CYC_MAX;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NUM_WAYS; i++) evict_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            checked_q   <= checked_d;
            pend_miss_q <= pend_miss_d;
            pend_way_q  <= pend_way_d;
            last_lat_q  <= last_lat_d;
            last_miss_q <= last_miss_d;
            last_way_q  <= last_way_d;
            txn_q       <= txn_d;
            miss_cnt_q  <= miss_cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            ovf_q       <= ovf_d;
            evict_q     <= evict_d;
        end
    end

    assign busy_o         = (state_q == RUN);
    assign cycle_o        = cycle_q;
    assign last_latency_o = last_lat_q;
    assign last_miss_o    = last_miss_q;
    assign last_way_o     = last_way_q;
    assign txn_count_o    = txn_q;
    assign miss_count_o   = miss_cnt_q;
    assign max_latency_o  = max_q;
    assign min_latency_o  = min_q;
    assign overflow_o     = ovf_q;
    assign way_evict_o    = evict_q[way_sel_i];
endmodule

// File: tb/tb_sm4_perf_monitor.sv
// tb/tb_sm4_perf_monitor.sv - randomized bench for sm4_perf_monitor against an edge-count reference model
module tb_sm4_perf_monitor;
    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [1:0]  sel_r;
    logic        busy;
    logic [7:0]  cycle_v, last_lat, max_lat, min_lat;
    logic        last_miss, ovf;
    logic [1:0]  last_way;
    logic [15:0] txn_cnt, miss_cnt, evict_v;

    int n_checks = 0;
    int n_pass   = 0;

    sm4_perf_monitor_if #(.NUM_WAYS(4)) evt_if ();

    sm4_perf_monitor #(.NUM_WAYS(4), .CYCLE_W(8), .CNT_W(16)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .evt            (evt_if),
        .clear_i        (clear),
        .way_sel_i      (sel_r),
        .busy_o         (busy),
        .cycle_o        (cycle_v),
        .last_latency_o (last_lat),
        .last_miss_o    (last_miss),
        .last_way_o     (last_way),
        .txn_count_o    (txn_cnt),
        .miss_count_o   (miss_cnt),
        .max_latency_o  (max_lat),
        .min_latency_o  (min_lat),
        .way_evict_o    (evict_v),
        .overflow_o     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a transaction is a start edge number; latency is simply edges elapsed
    bit m_busy, m_checked, m_pmiss, m_lmiss, m_ovf;
    int m_edge, m_start, m_pway, m_cycle, m_llat, m_lway;
    int m_txn, m_mc, m_max, m_min;
    int m_ev [4];

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_checked = 0; m_pmiss = 0; m_pway = 0; m_cycle = 0;
        m_llat = 0; m_lmiss = 0; m_lway = 0; m_txn = 0; m_mc = 0;
        m_max = 0; m_min = 255; m_ovf = 0;
        foreach (m_ev[i]) m_ev[i] = 0;
    endtask

    task automatic bump(inout int cnt);
        if (cnt == 65535) m_ovf = 1;
        else cnt = cnt + 1;
    endtask

    task automatic model_edge();
        int k;
        m_edge++;
        if (!m_busy) begin
            if (evt_if.start_i) begin
                m_busy = 1; m_start = m_edge; m_checked = 0;
                m_pmiss = 0; m_pway = 0; m_cycle = 0;
            end
        end else begin
            k = m_edge - m_start;
            m_cycle = sat(k, 255);
            if (k >= 256) m_ovf = 1;
            if (evt_if.check_i && !m_checked) begin
                m_checked = 1;
                m_pmiss   = evt_if.miss_i;
                m_pway    = evt_if.miss_i ? int'(evt_if.replace_way_i) : 0;
            end
            if (evt_if.done_i) begin
                m_busy  = 0;
                m_llat  = sat(k, 255);
                m_lmiss = m_pmiss;
                m_lway  = m_pway;
                bump(m_txn);
                if (m_pmiss) begin
                    bump(m_mc);
                    bump(m_ev[m_pway]);
                end
                if (m_llat > m_max) m_max = m_llat;
                if (m_llat < m_min) m_min = m_llat;
            end
        end
        if (clear) begin
            m_txn = 0; m_mc = 0; m_max = 0; m_min = 255; m_ovf = 0;
            foreach (m_ev[i]) m_ev[i] = 0;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        check_val("busy",      32'(busy),      32'(m_busy));
        check_val("cycle",     32'(cycle_v),   32'(m_cycle));
        check_val("last_lat",  32'(last_lat),  32'(m_llat));
        check_val("last_miss", 32'(last_miss), 32'(m_lmiss));
        check_val("last_way",  32'(last_way),  32'(m_lway));
        check_val("txn_cnt",   32'(txn_cnt),   32'(m_txn));
        check_val("miss_cnt",  32'(miss_cnt),  32'(m_mc));
        check_val("max_lat",   32'(max_lat),   32'(m_max));
        check_val("min_lat",   32'(min_lat),   32'(m_min));
        check_val("way_evict", 32'(evict_v),   32'(m_ev[sel_r]));
        check_val("overflow",  32'(ovf),       32'(m_ovf));
    endtask

    // Drive one cycle's inputs at the falling edge, let the model follow the rising edge, then compare
    task automatic step(input logic s, input logic c, input logic m, input logic [1:0] w,
                        input logic d, input logic cl);
        evt_if.start_i = s; evt_if.check_i = c; evt_if.miss_i = m;
        evt_if.replace_way_i = w; evt_if.done_i = d; clear = cl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 0, 0);
    endtask

    // Start at edge 0, done at edge lat, optional single check at edge chk_at
    task automatic run_txn(input int lat, input int chk_at, input logic cm, input logic [1:0] cw,
                           input logic clr_done);
        step(1, 0, 0, 2'd0, 0, 0);
        for (int i = 1; i < lat; i++) step(0, i == chk_at, cm, cw, 0, 0);
        step(0, chk_at == lat, cm, cw, 1, clr_done);
    endtask

    initial begin
        int lat;
        evt_if.start_i = 0; evt_if.check_i = 0; evt_if.miss_i = 0;
        evt_if.replace_way_i = 0; evt_if.done_i = 0;
        clear = 0; sel_r = 0; m_edge = 0; m_start = 0;
        reset_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        check_val("rst_min", 32'(min_lat), 32'd255);
        reset_n = 1;

        // Miss at edge 3 with victim way 2, done at edge 35
        sel_r = 2'd2;
        step(1, 0, 0, 2'd0, 0, 0);
        idle(2);
        step(0, 1, 1, 2'd2, 0, 0);
        idle(31);
        step(0, 0, 0, 2'd0, 1, 0);
        check_val("d1_lat",   32'(last_lat),  32'd35);
        check_val("d1_miss",  32'(last_miss), 32'd1);
        check_val("d1_way",   32'(last_way),  32'd2);
        check_val("d1_mcnt",  32'(miss_cnt),  32'd1);
        check_val("d1_evict", 32'(evict_v),   32'd1);
        check_val("d1_busy",  32'(busy),      32'd0);

        // Three hits
        step(0, 0, 0, 2'd0, 0, 1);
        run_txn(33, 5, 0, 2'd1, 0);
        run_txn(40, 1, 0, 2'd3, 0);
        run_txn(34, 0, 0, 2'd0, 0);
        check_val("d2_txn",  32'(txn_cnt),  32'd3);
        check_val("d2_mcnt", 32'(miss_cnt), 32'd0);
        check_val("d2_min",  32'(min_lat),  32'd33);
        check_val("d2_max",  32'(max_lat),  32'd40);

        // Long transaction saturates the latency
        run_txn(300, 0, 0, 2'd0, 0);
        check_val("d3_cycle", 32'(cycle_v),  32'd255);
        check_val("d3_lat",   32'(last_lat), 32'd255);
        check_val("d3_ovf",   32'(ovf),      32'd1);
        step(0, 0, 0, 2'd0, 0, 1);
        check_val("d3_clr_ovf", 32'(ovf),     32'd0);
        check_val("d3_clr_min", 32'(min_lat), 32'd255);
        check_val("d3_clr_txn", 32'(txn_cnt), 32'd0);

        // Hit check first, then a miss check coincident with done: only the first counts
        step(1, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 2'd1, 0, 0);
        idle(17);
        step(0, 1, 1, 2'd3, 1, 0);
        check_val("d4_miss", 32'(last_miss), 32'd0);
        check_val("d4_mcnt", 32'(miss_cnt),  32'd0);

        // Sole check arriving with done is honoured
        sel_r = 2'd1;
        run_txn(12, 12, 1, 2'd1, 0);
        check_val("d5_miss",  32'(last_miss), 32'd1);
        check_val("d5_way",   32'(last_way),  32'd1);
        check_val("d5_evict", 32'(evict_v),   32'd1);

        // Clear coincident with done
        run_txn(21, 0, 0, 2'd0, 1);
        check_val("d6_txn", 32'(txn_cnt),  32'd0);
        check_val("d6_lat", 32'(last_lat), 32'd21);

        // Asynchronous reset mid-transaction
        run_txn(7, 2, 1, 2'd3, 0);
        step(1, 0, 0, 2'd0, 0, 0);
        idle(10);
        #2 reset_n = 0;
        #1;
        model_reset();
        check_all();
        check_val("d7_busy", 32'(busy),    32'd0);
        check_val("d7_txn",  32'(txn_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1;
        run_txn(9, 4, 1, 2'd0, 0);
        check_val("d7_next_lat", 32'(last_lat), 32'd9);
        check_val("d7_next_txn", 32'(txn_cnt),  32'd1);

        // Randomized traffic including ignored strobes and occasional clears
        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                sel_r = 2'($urandom_range(0, 3));
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 30) == 0);
            end
            lat = $urandom_range(1, 45);
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
            for (int i = 1; i < lat; i++) begin
                sel_r = 2'($urandom_range(0, 3));
                step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0,
                     $urandom_range(0, 50) == 0);
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1,
                 $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
